cve2_iter_div_unit: RTL and testbench
=====================================

Name: cve2_iter_div_unit

Overview:
- Iterative radix-2 integer divide/remainder unit on the responder side of the EX-stage offload handshake: in_valid/in_ready, flush, out_valid/out_ready, busy, tag.
- Signalling is identical to the interface EX uses to issue to the FPU, so EX can offload RV32M DIV/DIVU/REM/REMU to it.
- One operation in flight. 33-cycle latency for normal operands, 1 cycle for special cases.

Parameters:
- TagWidth, 1: width of the opaque tag carried from request to response.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- operand_a_i  in  32  dividend.
- operand_b_i  in  32  divisor.
- op_i  in  div_op_e (1)  DIV_OP_DIV returns the quotient; DIV_OP_REM returns the remainder.
- signed_i  in  1  1 = signed operands, 0 = unsigned.
- tag_i  in  TagWidth  request tag.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  unit can accept a request.
- flush_i  in  1  kill any in-flight operation.
- result_o  out  32  result.
- div_zero_o  out  1  divisor was zero.
- tag_o  out  TagWidth  tag of the response.
- out_valid_o  out  1  response valid.
- out_ready_i  in  1  consumer accepts the response.
- busy_o  out  1  an operation is in flight (state != IDLE).

Behaviour:
- Reset: state IDLE, counter 0, all data registers 0. Outputs: in_ready_o=1, out_valid_o=0, busy_o=0, result_o=0, div_zero_o=0, tag_o=0.
- States: IDLE, CALC, DONE.
- in_ready_o = (state==IDLE) & ~flush_i.
- Accept: a request is accepted at an edge where in_valid_i & in_ready_o. At that edge the unit registers op, signed, tag, sign_a, sign_b, |a|, |b|. Magnitudes are used only when signed_i=1; otherwise raw values.
- Special cases, checked at accept (IDLE -> DONE):
  - b==0: quotient 0xFFFFFFFF, remainder a, div_zero=1.
  - signed_i & a==0x80000000 & b==0xFFFFFFFF: quotient 0x80000000, remainder 0, div_zero=0.
  - In both cases out_valid_o rises after the first edge following accept.
- Normal case, IDLE -> CALC with counter=31.
  - Each CALC cycle does one restoring step: rem' = {rem[31:0], dividend_msb}; if rem' >= divisor, subtract and shift quotient bit 1, else shift 0.
  - Remainder uses a 33-bit working width; the dividend shifts left.
  - counter==0 -> DONE. 32 CALC cycles; out_valid_o rises after the 33rd edge following accept.
- DONE: out_valid_o=1. result_o is computed from the registered values:
  - DIV: quotient, negated if signed & (sign_a ^ sign_b).
  - REM: remainder, negated if signed & sign_a.
  - Special-case results are used without sign fix-up.
- result_o, div_zero_o and tag_o stay stable while out_valid_o & ~out_ready_i, held indefinitely.
- DONE & out_ready_i -> IDLE at that edge. No accept in that same cycle, so back-to-back throughput is 1 op per 34 cycles minimum.
- Flush: flush_i=1 in any state -> IDLE at the next edge, out_valid_o=0, result discarded, no response ever emitted for it. flush_i together with in_valid_i in IDLE: no accept.
- Async reset mid-operation: immediately IDLE with reset values; the in-flight op is lost.
- busy_o = (state != IDLE), including DONE.
- When out_valid_o=0, result_o is don't-care; the implementation drives the data registers.

Decomposition:
- cve2_pkg gains typedef div_op_e (DIV_OP_DIV, DIV_OP_REM) and typedef div_state_e (DIV_IDLE, DIV_CALC, DIV_DONE).
- Single module. The restoring step is too small to justify a sub-module.
- EX-side integration (selecting this unit, muxing result_o) is outside this block.

Test Plan:
- DIVU 100/7, tag=1 -> out_valid_o after 33 edges, result_o=14, tag_o=1, div_zero_o=0; REMU same operands -> 2.
- DIV signed -7/2 -> 0xFFFFFFFD (-3); REM signed -7/2 -> 0xFFFFFFFF (-1); DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 1.
- DIV 5/0 -> after 1 edge result_o=0xFFFFFFFF, div_zero_o=1; REM 5/0 -> 5, div_zero_o=1.
- Signed DIV 0x80000000/0xFFFFFFFF -> 0x80000000 after 1 edge; REM same operands -> 0.
- out_ready_i=0 for 10 cycles in DONE -> out_valid_o, result_o, tag_o held constant and busy_o=1; in_valid_i meanwhile not accepted (in_ready_o=0).
- flush_i at CALC cycle 10 -> IDLE next edge, no out_valid_o pulse; next request DIVU 9/3 -> 3 with correct latency.
- Reset asserted mid-CALC -> immediately in_ready_o=1, out_valid_o=0, busy_o=0.

Source files
------------

// File: rtl/cve2_pkg.sv
// cve2_pkg: shared types for the iterative divide unit.
package cve2_pkg;
  typedef enum logic {
    DIV_OP_DIV = 1'b0,
    DIV_OP_REM = 1'b1
  } div_op_e;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;
  localparam int unsigned DivCntW = 5;
  localparam logic [DivCntW-1:0] DivCntInit = 5'd31;
endpackage

// File: rtl/cve2_iter_div_unit.sv
// cve2_iter_div_unit: radix-2 restoring divide/remainder unit behind a valid/ready offload handshake.
module cve2_iter_div_unit
  import cve2_pkg::*;
#(
  parameter int unsigned TagWidth = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [31:0]         operand_a_i,
  input  logic [31:0]         operand_b_i,
  input  div_op_e             op_i,
  input  logic                signed_i,
  input  logic [TagWidth-1:0] tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output logic [31:0]         result_o,
  output logic                div_zero_o,
  output logic [TagWidth-1:0] tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o
);
  div_state_e          r_state, w_state_nx;
  logic [DivCntW-1:0]  r_cnt;
  div_op_e             r_op;
  logic                r_signed, r_sign_a, r_sign_b, r_special, r_div_zero;
  logic [TagWidth-1:0] r_tag;
  logic [31:0]         r_dividend, r_divisor, r_rem, r_quot;
  logic                w_accept, w_b_zero, w_ovf, w_ge;
  logic [31:0]         w_abs_a, w_abs_b, w_quot_fix, w_rem_fix;
  logic [32:0]         w_rem_sh, w_sub;
  assign w_accept = in_valid_i & in_ready_o;
  assign w_abs_a  = (signed_i & operand_a_i[31]) ? -operand_a_i : operand_a_i;
  assign w_abs_b  = (signed_i & operand_b_i[31]) ? -operand_b_i : operand_b_i;
  assign w_b_zero = operand_b_i == 32'd0;
  assign w_ovf    = signed_i & (operand_a_i == 32'h8000_0000) & (operand_b_i == 32'hFFFF_FFFF);
  // The partial remainder is always below the divisor, so the sign of the
  // 33-bit difference alone decides whether the divisor fits.
  assign w_rem_sh = {1'b0, r_rem, r_dividend[31]};
  assign w_sub    = w_rem_sh - {1'b0, r_divisor};
  assign w_ge     = ~w_sub[32];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= DIV_IDLE;
    else         r_state <= w_state_nx;
  end
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      DIV_IDLE: w_state_nx = w_accept ? ((w_b_zero | w_ovf) ? DIV_DONE : DIV_CALC) : DIV_IDLE;
      DIV_CALC: w_state_nx = (r_cnt == '0) ? DIV_DONE : DIV_CALC;
      DIV_DONE: w_state_nx = out_ready_i ? DIV_IDLE : DIV_DONE;
      default:  w_state_nx = DIV_IDLE;
    endcase
    if (flush_i) w_state_nx = DIV_IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt      <= '0;
      r_op       <= DIV_OP_DIV;
      r_signed   <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_special  <= 1'b0;
      r_div_zero <= 1'b0;
      r_tag      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
    end else if (w_accept) begin
      r_cnt      <= DivCntInit;
      r_op       <= op_i;
      r_signed   <= signed_i;
      r_sign_a   <= operand_a_i[31];
      r_sign_b   <= operand_b_i[31];
      r_special  <= w_b_zero | w_ovf;
      r_div_zero <= w_b_zero;
      r_tag      <= tag_i;
      r_dividend <= w_abs_a;
      r_divisor  <= w_abs_b;
      r_rem      <= w_b_zero ? operand_a_i : 32'd0;
      r_quot     <= w_b_zero ? 32'hFFFF_FFFF : (w_ovf ? 32'h8000_0000 : 32'd0);
    end else if (r_state == DIV_CALC) begin
      r_cnt      <= r_cnt - 1'b1;
      r_dividend <= {r_dividend[30:0], 1'b0};
      r_rem      <= w_ge ? w_sub[31:0] : w_rem_sh[31:0];
      r_quot     <= {r_quot[30:0], w_ge};
    end
  end
  assign w_quot_fix  = (r_signed & (r_sign_a ^ r_sign_b) & ~r_special) ? -r_quot : r_quot;
  assign w_rem_fix   = (r_signed & r_sign_a & ~r_special) ? -r_rem : r_rem;
  assign result_o    = (r_op == DIV_OP_REM) ? w_rem_fix : w_quot_fix;
  assign div_zero_o  = r_div_zero;
  assign tag_o       = r_tag;
  assign in_ready_o  = (r_state == DIV_IDLE) & ~flush_i;
  assign out_valid_o = r_state == DIV_DONE;
  assign busy_o      = r_state != DIV_IDLE;
endmodule

// File: tb/tb_cve2_iter_div_unit.sv
// tb_cve2_iter_div_unit: directed tests against a cycle-level arithmetic model of the divide unit.
module tb_cve2_iter_div_unit;
  import cve2_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  div_op_e     op = DIV_OP_DIV;
  logic        sgn = 1'b0, tag = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic        in_ready, div_zero, tag_out, out_valid, busy;
  logic [31:0] result;
  int          n_cmp = 0, n_bad = 0;
  logic        m_busy, m_valid, m_dz, m_tag;
  logic [31:0] m_res;
  int          m_cnt;
  cve2_iter_div_unit #(.TagWidth(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .operand_a_i(a), .operand_b_i(b), .op_i(op),
    .signed_i(sgn), .tag_i(tag), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .flush_i(flush), .result_o(result), .div_zero_o(div_zero), .tag_o(tag_out),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [32:0] expect_of(input logic [31:0] x, input logic [31:0] y,
                                            input div_op_e o, input logic s);
    int sx, sy;
    sx = x;
    sy = y;
    if (y == 0) return {1'b1, (o == DIV_OP_REM) ? x : 32'hFFFF_FFFF};
    if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      return {1'b0, (o == DIV_OP_REM) ? 32'd0 : 32'h8000_0000};
    if (s) return {1'b0, (o == DIV_OP_REM) ? 32'(sx % sy) : 32'(sx / sy)};
    return {1'b0, (o == DIV_OP_REM) ? x % y : x / y};
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_valid <= 0; m_cnt <= 0; m_res <= 0; m_dz <= 0; m_tag <= 0;
    end else if (flush) begin
      m_busy <= 0; m_valid <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        {m_dz, m_res} <= expect_of(a, b, op, sgn);
        m_tag  <= tag;
        m_busy <= 1;
        if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) m_valid <= 1;
        else m_cnt <= 32;
      end
    end else if (m_valid) begin
      if (out_ready) begin m_busy <= 0; m_valid <= 0; end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_valid <= 1;
    end
  end
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(!m_busy && !flush));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid && out_valid) begin
      chk("result", result, m_res);
      chk("div_zero", 32'(div_zero), 32'(m_dz));
      chk("tag", 32'(tag_out), 32'(m_tag));
    end
  end
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input div_op_e o,
                        input logic s, input logic t, input logic [31:0] exp,
                        input logic exp_dz, input int lat, input int hold);
    int n;
    @(negedge clk); #1;
    a = x; b = y; op = o; sgn = s; tag = t; in_valid = 1; out_ready = 0;
    @(negedge clk); #1;
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    #1;
    chk("latency", 32'(n), 32'(lat));
    chk("lit_result", result, exp);
    chk("lit_div_zero", 32'(div_zero), 32'(exp_dz));
    chk("lit_tag", 32'(tag_out), 32'(t));
    if (hold > 0) begin
      a = 32'd1; b = 32'd1; in_valid = 1;
      repeat (hold) begin
        @(negedge clk); #1;
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_result", result, exp);
        chk("hold_tag", 32'(tag_out), 32'(t));
        chk("hold_busy", 32'(busy), 32'd1);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 0;
    end
    out_ready = 1;
    @(negedge clk); #1;
    out_ready = 0;
    chk("idle_after", 32'(busy), 32'd0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    chk("rst_tag", 32'(tag_out), 32'd0);
    rst_n = 1;
    run_op(32'd100, 32'd7, DIV_OP_DIV, 0, 1, 32'd14, 0, 33, 0);
    run_op(32'd100, 32'd7, DIV_OP_REM, 0, 0, 32'd2, 0, 33, 0);
    run_op(-32'sd7, 32'd2, DIV_OP_DIV, 1, 1, 32'hFFFF_FFFD, 0, 33, 0);
    run_op(-32'sd7, 32'd2, DIV_OP_REM, 1, 0, 32'hFFFF_FFFF, 0, 33, 0);
    run_op(32'd7, -32'sd2, DIV_OP_DIV, 1, 1, 32'hFFFF_FFFD, 0, 33, 0);
    run_op(32'd7, -32'sd2, DIV_OP_REM, 1, 0, 32'd1, 0, 33, 0);
    run_op(32'd5, 32'd0, DIV_OP_DIV, 0, 1, 32'hFFFF_FFFF, 1, 1, 0);
    run_op(32'd5, 32'd0, DIV_OP_REM, 1, 0, 32'd5, 1, 1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, DIV_OP_DIV, 1, 1, 32'h8000_0000, 0, 1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, DIV_OP_REM, 1, 0, 32'd0, 0, 1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, DIV_OP_DIV, 0, 0, 32'd0, 0, 33, 0);
    run_op(32'hFFFF_FFFF, 32'd10, DIV_OP_REM, 0, 1, 32'd5, 0, 33, 0);
    run_op(32'd1000, 32'd33, DIV_OP_DIV, 0, 1, 32'd30, 0, 33, 10);
    @(negedge clk); #1;
    a = 32'd1000; b = 32'd3; op = DIV_OP_DIV; sgn = 0; in_valid = 1;
    @(negedge clk); #1;
    in_valid = 0;
    repeat (9) @(negedge clk);
    #1;
    flush = 1; in_valid = 1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); #1;
    flush = 0; in_valid = 0;
    chk("flush_busy", 32'(busy), 32'd0);
    repeat (40) begin
      @(negedge clk); #1;
      chk("flush_no_resp", 32'(out_valid), 32'd0);
    end
    run_op(32'd9, 32'd3, DIV_OP_DIV, 0, 1, 32'd3, 0, 33, 0);
    @(negedge clk); #1;
    a = 32'd50; b = 32'd4; in_valid = 1;
    @(negedge clk); #1;
    in_valid = 0;
    repeat (5) @(negedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk); #1;
    rst_n = 1;
    run_op(32'd50, 32'd4, DIV_OP_REM, 0, 1, 32'd2, 0, 33, 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
